keccak_rho_pi_ctrl: RTL and testbench
=====================================

KECCAK_RHO_PI_CTRL -- requirements
Module: keccak_rho_pi_ctrl

Interface
REQ-001 SHALL have parameter BW_LANE, default 64, lane width in bits; only the value 64 is supported.
REQ-002 SHALL have parameter BW_N, default 9, width of the rotate-amount operand passed to the shared rotator.
REQ-003 SHALL have port i_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rstn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port i_start, input, 1, start request; sampled on each rising edge.
REQ-006 SHALL have port i_state, input, 1600, Keccak state A; lane i = x+5y occupies bits [64i+63:64i].
REQ-007 SHALL have port o_state, output, 1600, result state B, same lane layout as i_state.
REQ-008 SHALL have port o_busy, output, 1, high while a transform is in progress.
REQ-009 SHALL have port o_done, output, 1, single-cycle completion pulse.

Function
REQ-010 SHALL compute the combined rho+pi step: B[y][(2x+3y) mod 5] = ROL64(A[x][y], r[x][y]), using a single rotate-left-64 unit time-shared across all lanes.
REQ-011 SHALL use rotation offsets r indexed by i=x+5y, i=0..24: 0,1,62,28,27,36,44,6,55,20,3,10,43,25,39,41,45,15,21,8,18,2,61,56,14; the offsets are held in a constant table and zero-extended to BW_N.
REQ-012 SHALL implement FSM states IDLE, RUN and DONE; the reset state is IDLE.
REQ-013 IDLE: when i_start=1, SHALL capture i_state into an internal 1600-bit source register, clear the 5-bit lane counter to 0 and go to RUN.
REQ-014 RUN: each cycle SHALL rotate source lane cnt by r[cnt] and write the result into destination lane X'+5Y', with X'=y, Y'=(2x+3y) mod 5, x=cnt mod 5, y=cnt div 5; it SHALL then increment cnt.
REQ-015 RUN: in the cycle where cnt=24, SHALL write that lane and go to DONE; cnt SHALL NOT wrap to 0 within RUN.
REQ-016 DONE: SHALL assert o_done for exactly one cycle, then return to IDLE.
REQ-017 Latency: SHALL accept the start on edge 0, write lanes on edges 1..25 and present o_done=1 during the cycle following edge 25; total 26 cycles from start acceptance to the done pulse.
REQ-018 SHALL set o_busy=1 in RUN and DONE and o_busy=0 in IDLE.
REQ-019 SHALL drive o_state directly from the destination register; o_state is valid from the o_done cycle and SHALL hold unchanged until the next accepted start writes the first lane.
REQ-020 SHALL ignore i_start while o_busy=1; changes on i_state after capture SHALL NOT affect the result.
REQ-021 When i_start=1 in the DONE cycle, SHALL NOT accept that start; a start held high SHALL be accepted in the following IDLE cycle.
REQ-022 SHALL keep rotate amounts in 0..63, so ROL64 by 0 returns the lane unchanged and no shift by 64 ever occurs.
REQ-023 SHALL derive the destination index from a constant 25-entry table or equivalent combinational logic; no divider is inferred.

Reset
REQ-024 When i_rstn=0, SHALL asynchronously force the FSM to IDLE, cnt=0, o_busy=0, o_done=0, and the source and destination registers to all zeros.
REQ-025 Reset asserted during RUN SHALL abort the transform; after release o_state=0 and the block SHALL wait for a new i_start.
REQ-026 Reset deassertion SHALL take effect on the next rising edge; i_start sampled on that edge SHALL be accepted.

Verification
REQ-027 Lane 1 = 0x1, all other lanes 0, pulse start -> at o_done, lane 10 = 0x0000000000000002, all other lanes 0.
REQ-028 Lane 24 = 0x1, others 0 -> at o_done, lane 4 = 0x0000000000004000, all other lanes 0.
REQ-029 Lane 0 = 0xDEADBEEFCAFEF00D, others 0 -> at o_done, lane 0 unchanged, all other lanes 0; o_done asserted exactly 26 cycles after start acceptance.
REQ-030 Random state, 1000 iterations -> o_state matches a software rho+pi model, o_busy high for exactly 26 cycles per transform.
REQ-031 i_start held high continuously -> back-to-back transforms with one IDLE cycle between o_done and the next capture; starts raised during RUN are ignored.
REQ-032 i_rstn pulled low at cnt=12 -> o_busy=0, o_state=0 immediately (asynchronously); a subsequent start produces a correct result.

Source files
------------

// File: rtl/keccak_rho_pi_ctrl.sv
// rtl/keccak_rho_pi_ctrl.sv - Keccak rho+pi step, one lane per cycle through a shared ROL64
module keccak_rho_pi_ctrl #(
  parameter int BW_LANE = 64,
  parameter int BW_N    = 9
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic                   i_start,
  input  logic [25*BW_LANE-1:0]  i_state,
  output logic [25*BW_LANE-1:0]  o_state,
  output logic                   o_busy,
  output logic                   o_done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                      state_q, state_d;
  logic [4:0]                  cnt_q, cnt_d;
  logic [24:0][BW_LANE-1:0]    src_q, src_d;
  logic [24:0][BW_LANE-1:0]    dst_q, dst_d;

  logic [BW_LANE-1:0]          lane_in;
  logic [BW_LANE-1:0]          lane_rot;
  logic [2*BW_LANE-1:0]        rot_wide;
  logic [BW_N-1:0]             rot_amt;

  function automatic logic [5:0] rot_off(input logic [4:0] i);
    case (i)
      5'd0:  rot_off = 6'd0;   5'd1:  rot_off = 6'd1;   5'd2:  rot_off = 6'd62;
      5'd3:  rot_off = 6'd28;  5'd4:  rot_off = 6'd27;  5'd5:  rot_off = 6'd36;
      5'd6:  rot_off = 6'd44;  5'd7:  rot_off = 6'd6;   5'd8:  rot_off = 6'd55;
      5'd9:  rot_off = 6'd20;  5'd10: rot_off = 6'd3;   5'd11: rot_off = 6'd10;
      5'd12: rot_off = 6'd43;  5'd13: rot_off = 6'd25;  5'd14: rot_off = 6'd39;
      5'd15: rot_off = 6'd41;  5'd16: rot_off = 6'd45;  5'd17: rot_off = 6'd15;
      5'd18: rot_off = 6'd21;  5'd19: rot_off = 6'd8;   5'd20: rot_off = 6'd18;
      5'd21: rot_off = 6'd2;   5'd22: rot_off = 6'd61;  5'd23: rot_off = 6'd56;
      5'd24: rot_off = 6'd14;
      default: rot_off = 6'd0;
    endcase
  endfunction

  // Destination lane y + 5*((2x+3y) mod 5), precomputed so no divider appears.
  function automatic logic [4:0] dst_idx(input logic [4:0] i);
    case (i)
      5'd0:  dst_idx = 5'd0;   5'd1:  dst_idx = 5'd10;  5'd2:  dst_idx = 5'd20;
      5'd3:  dst_idx = 5'd5;   5'd4:  dst_idx = 5'd15;  5'd5:  dst_idx = 5'd16;
      5'd6:  dst_idx = 5'd1;   5'd7:  dst_idx = 5'd11;  5'd8:  dst_idx = 5'd21;
      5'd9:  dst_idx = 5'd6;   5'd10: dst_idx = 5'd7;   5'd11: dst_idx = 5'd17;
      5'd12: dst_idx = 5'd2;   5'd13: dst_idx = 5'd12;  5'd14: dst_idx = 5'd22;
      5'd15: dst_idx = 5'd23;  5'd16: dst_idx = 5'd8;   5'd17: dst_idx = 5'd18;
      5'd18: dst_idx = 5'd3;   5'd19: dst_idx = 5'd13;  5'd20: dst_idx = 5'd14;
      5'd21: dst_idx = 5'd24;  5'd22: dst_idx = 5'd9;   5'd23: dst_idx = 5'd19;
      5'd24: dst_idx = 5'd4;
      default: dst_idx = 5'd0;
    endcase
  endfunction

  // Rotating a doubled lane and keeping the top half avoids any shift by 64.
  assign lane_in  = src_q[cnt_q];
  assign rot_amt  = BW_N'(rot_off(cnt_q));
  assign rot_wide = {lane_in, lane_in} << rot_amt;
  assign lane_rot = rot_wide[2*BW_LANE-1 -: BW_LANE];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    dst_d   = dst_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          src_d   = i_state;
          cnt_d   = 5'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        dst_d[dst_idx(cnt_q)] = lane_rot;
        if (cnt_q == 5'd24) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      src_q   <= '0;
      dst_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
    end
  end

  assign o_state = dst_q;
  assign o_busy  = (state_q != IDLE);
  assign o_done  = (state_q == DONE);

endmodule

// File: tb/tb_keccak_rho_pi_ctrl.sv
// tb/tb_keccak_rho_pi_ctrl.sv - directed and random checks of keccak_rho_pi_ctrl
module tb_keccak_rho_pi_ctrl;

  logic          clk;
  logic          rstn;
  logic          start;
  logic [1599:0] st_in;
  logic [1599:0] st_out;
  logic          busy;
  logic          done;

  int n_cmp;
  int n_bad;

  keccak_rho_pi_ctrl #(.BW_LANE(64), .BW_N(9)) dut (
    .i_clk   (clk),
    .i_rstn  (rstn),
    .i_start (start),
    .i_state (st_in),
    .o_state (st_out),
    .o_busy  (busy),
    .o_done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int ROFF [25] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43, 25, 39,
                               41, 45, 15, 21, 8, 18, 2, 61, 56, 14};

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [1599:0] model(input logic [1599:0] a);
    logic [1599:0] b;
    logic [63:0]   l;
    int            r, dx, dy;
    b = '0;
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        l  = a[64*(x+5*y) +: 64];
        r  = ROFF[x+5*y];
        if (r != 0) l = (l << r) | (l >> (64 - r));
        dx = y;
        dy = (2*x + 3*y) % 5;
        b[64*(dx+5*dy) +: 64] = l;
      end
    end
    return b;
  endfunction

  task automatic check_state(input string tag, input logic [1599:0] exp);
    for (int i = 0; i < 25; i++)
      check_eq($sformatf("%s_lane%0d", tag, i), st_out[64*i +: 64], exp[64*i +: 64]);
  endtask

  // Pulses start for one edge, then waits for o_done; lat is the negedge count at done.
  task automatic run_xform(input logic [1599:0] a, output int lat, output int busy_cyc);
    lat = 0;
    busy_cyc = 0;
    @(negedge clk);
    st_in = a;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    st_in = {50{32'hA5A5_5A5A}};
    for (int k = 1; k <= 60; k++) begin
      if (k > 1) @(negedge clk);
      if (busy) busy_cyc++;
      if (done) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) check_eq("done_timeout", 64'd0, 64'd1);
  endtask

  function automatic logic [1599:0] one_lane(input int idx, input logic [63:0] v);
    logic [1599:0] s;
    s = '0;
    s[64*idx +: 64] = v;
    return s;
  endfunction

  logic [1599:0] a, exp_b;
  int lat, bc;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rstn  = 1'b0;
    start = 1'b0;
    st_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_done", {63'd0, done}, 64'd0);
    check_eq("rst_state_or", {63'd0, |st_out}, 64'd0);
    rstn = 1'b1;

    run_xform(one_lane(1, 64'h1), lat, bc);
    check_state("v1", one_lane(10, 64'h2));

    run_xform(one_lane(24, 64'h1), lat, bc);
    check_state("v24", one_lane(4, 64'h4000));

    run_xform(one_lane(0, 64'hDEADBEEFCAFEF00D), lat, bc);
    check_state("v0", one_lane(0, 64'hDEADBEEFCAFEF00D));
    check_eq("v0_latency", 64'(lat), 64'd26);
    check_eq("v0_busy_cycles", 64'(bc), 64'd26);
    @(negedge clk);
    check_eq("post_done_busy", {63'd0, busy}, 64'd0);
    check_eq("post_done_hold", st_out[63:0], 64'hDEADBEEFCAFEF00D);

    // Start raised mid-run and input churn must not disturb the result.
    a = {50{$urandom()}};
    exp_b = model(a);
    @(negedge clk);
    st_in = a;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1;
    st_in = ~a;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 40 && !done; k++) @(negedge clk);
    check_eq("ign_done", {63'd0, done}, 64'd1);
    check_state("ign", exp_b);

    // Start held high: one IDLE cycle between done and the next capture.
    a = {50{$urandom()}};
    @(negedge clk);
    st_in = a;
    start = 1'b1;
    for (int k = 0; k < 40 && !done; k++) @(negedge clk);
    check_eq("b2b_done1", {63'd0, done}, 64'd1);
    check_state("b2b1", model(a));
    st_in = ~a;
    @(negedge clk);
    check_eq("b2b_idle_gap", {63'd0, busy}, 64'd0);
    @(negedge clk);
    check_eq("b2b_recapture", {63'd0, busy}, 64'd1);
    start = 1'b0;
    lat = 0;
    for (int k = 2; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
    check_eq("b2b_latency2", 64'(lat), 64'd26);
    check_state("b2b2", model(~a));

    // Asynchronous reset in the middle of a run at cnt=12.
    a = {50{$urandom()}};
    @(negedge clk);
    st_in = a;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    #1 rstn = 1'b0;
    #1;
    check_eq("arst_busy", {63'd0, busy}, 64'd0);
    check_eq("arst_state_or", {63'd0, |st_out}, 64'd0);
    @(negedge clk);
    check_eq("arst_idle", {63'd0, busy}, 64'd0);
    start = 1'b1;
    st_in = one_lane(2, 64'h1);
    rstn  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check_eq("rel_accept", {63'd0, busy}, 64'd1);
    for (int k = 0; k < 40 && !done; k++) @(negedge clk);
    check_state("rel", one_lane(20, 64'h4000_0000_0000_0000));

    for (int it = 0; it < 1000; it++) begin
      for (int i = 0; i < 50; i++) a[32*i +: 32] = $urandom();
      run_xform(a, lat, bc);
      check_state($sformatf("rnd%0d", it), model(a));
      check_eq($sformatf("rnd%0d_busy", it), 64'(bc), 64'd26);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
